// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner and prefetch FIFO feeding decode; optional misaligned-redirect fault via IFETCH_MISALIGN_CHECK_EN
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic [31:0]                   imem_addr,
  input  logic [31:0]                   imem_instr,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  output logic                          if_valid,
  input  logic                          if_ready,
  output logic [31:0]                   if_pc,
  output logic [31:0]                   if_instr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fetch_fault
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
`ifdef IFETCH_MISALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  typedef enum logic {FETCH, FAULT} state_e;
  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            fault_q, fault_d;
  logic [31:0]     pc_mem    [FIFO_DEPTH];
  logic [31:0]     instr_mem [FIFO_DEPTH];
  logic            pop, push, misalign;
  logic [31:0]     redir_al;
  assign misalign   = CHK & (|redirect_pc[1:0]);
  assign redir_al   = {redirect_pc[31:2], 2'b00};
  assign if_valid   = count_q != '0;
  assign pop        = if_valid & if_ready;
  assign push       = (state_q == FETCH) & ~redirect_valid & ((count_q < CW'(FIFO_DEPTH)) | pop);
  assign imem_addr  = fetch_pc_q;
  assign if_pc      = if_valid ? pc_mem[rd_ptr_q] : 32'h0;
  assign if_instr   = if_valid ? instr_mem[rd_ptr_q] : 32'h0;
  assign fifo_count = count_q;
  assign fetch_fault = fault_q;
  // next state: a redirect flushes everything and wins over push/pop
  always_comb begin
    fetch_pc_d = redirect_valid ? redir_al : push ? fetch_pc_q + 32'd4 : fetch_pc_q;
    rd_ptr_d   = redirect_valid ? '0 : rd_ptr_q + PW'(pop);
    wr_ptr_d   = redirect_valid ? '0 : wr_ptr_q + PW'(push);
    count_d    = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
    state_d    = redirect_valid ? (misalign ? FAULT : FETCH) : state_q;
    fault_d    = redirect_valid ? misalign : fault_q;
  end
  // control registers, dropped immediately on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= FETCH;
      fault_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      fault_q    <= fault_d;
    end
  end
  // FIFO storage; stale contents are masked by count so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= fetch_pc_q;
      instr_mem[wr_ptr_q] <= imem_instr;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: randomized scoreboard bench for the fetch unit
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_instr;
  logic [2:0]  fifo_count;
  logic        fetch_fault;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  instruction_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .fifo_count(fifo_count), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {2'b00, a[31:2]} + 32'd1;
  endfunction

  assign imem_instr = mem_f(imem_addr);

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // decode sees a contiguous PC stream starting at the last redirect/reset target
  task automatic refill(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 2000; i++) exp_q.push_back(pc + 32'(4 * i));
  endtask

  // called just after a rising edge; the redirect takes effect on the next edge
  task automatic redirect(input logic [31:0] pc, input bit fault);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(posedge clk);
    exp_q.delete();
    if (!fault) refill({pc[31:2], 2'b00});
    #1 redirect_valid = 1'b0;
  endtask

  // monitor: every handshake must deliver the next expected stream entry
  always @(negedge clk) begin
    if (rst_n) begin
      chk("count_range", 32'(fifo_count <= 3'd4), 32'd1);
      chk("valid_vs_count", 32'(if_valid), 32'(fifo_count != 3'd0));
`ifndef IFETCH_MISALIGN_CHECK_EN
      chk("fault_tied0", 32'(fetch_fault), 32'd0);
`endif
      if (if_valid && if_ready) begin
        if (exp_q.size() == 0) chk("unexpected_pop", if_pc, 32'hxxxx_xxxx);
        else begin
          logic [31:0] p;
          p = exp_q.pop_front();
          chk("sb_pc", if_pc, p);
          chk("sb_instr", if_instr, mem_f(p));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    refill(32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    // test 1: streaming with decode always ready
    @(posedge clk); #1 rst_n = 1'b1; if_ready = 1'b1;
    @(negedge clk);
    chk("t1_valid", 32'(if_valid), 32'd0);
    @(negedge clk);
    chk("t1_first_pc", if_pc, 32'h0);
    chk("t1_first_instr", if_instr, 32'h1);
    repeat (8) @(negedge clk);
    // test 5: async reset with three entries pending
    @(posedge clk); #1 if_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("t5_pre_count", 32'(fifo_count), 32'd3);
    #1 rst_n = 1'b0; refill(32'h0);
    #1;
    chk("t5_valid", 32'(if_valid), 32'd0);
    chk("t5_count", 32'(fifo_count), 32'd0);
    chk("t5_addr", imem_addr, 32'h0);
    // test 2: stall fills the FIFO and freezes the fetch PC
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t2_count", 32'(fifo_count), 32'd4);
    chk("t2_addr", imem_addr, 32'h10);
    @(negedge clk);
    chk("t2_addr_hold", imem_addr, 32'h10);
    @(posedge clk); #1 if_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_no_gap", 32'(if_valid), 32'd1);
      chk("t2_pc", if_pc, 32'(4 * i));
    end
    // test 3: redirect from a full FIFO with a pop in the same cycle
    @(posedge clk); #1 if_ready = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("t3_full", 32'(fifo_count), 32'd4);
    if_ready = 1'b1;
    redirect(32'h40, 1'b0);
    @(negedge clk);
    chk("t3_bubble_valid", 32'(if_valid), 32'd0);
    chk("t3_bubble_count", 32'(fifo_count), 32'd0);
    @(negedge clk);
    chk("t3_pc", if_pc, 32'h40);
    chk("t3_instr", if_instr, 32'd17);
    // test 4: fetch PC wraps past the top of the address space
    @(posedge clk); #1 redirect(32'hFFFF_FFFC, 1'b0);
    @(negedge clk);
    @(negedge clk); chk("t4_pc0", if_pc, 32'hFFFF_FFFC);
    @(negedge clk); chk("t4_pc1", if_pc, 32'h0);
    @(negedge clk); chk("t4_pc2", if_pc, 32'h4);
    // back-to-back redirects: the last one wins
    @(posedge clk); #1 redirect(32'h100, 1'b0);
    redirect(32'h200, 1'b0);
    @(negedge clk); chk("b2b_bubble", 32'(if_valid), 32'd0);
    @(negedge clk); chk("b2b_pc", if_pc, 32'h200);
`ifdef IFETCH_MISALIGN_CHECK_EN
    // test 6: misaligned redirect faults until an aligned redirect
    @(posedge clk); #1 redirect(32'h22, 1'b1);
    @(negedge clk); chk("t6_fault", 32'(fetch_fault), 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("t6_no_push", 32'(fifo_count), 32'd0);
      chk("t6_sticky", 32'(fetch_fault), 32'd1);
    end
    @(posedge clk); #1 redirect(32'h80, 1'b0);
    @(negedge clk); chk("t6_clear", 32'(fetch_fault), 32'd0);
    @(negedge clk); chk("t6_pc", if_pc, 32'h80);
`else
    // low redirect bits are ignored when the check is disabled
    @(posedge clk); #1 redirect(32'h22, 1'b0);
    @(negedge clk);
    @(negedge clk); chk("mis_pc", if_pc, 32'h20);
    chk("mis_fault", 32'(fetch_fault), 32'd0);
`endif
    // random traffic: back-pressure and occasional redirects
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      if_ready = ($urandom % 4) != 0;
      if (($urandom % 25) == 0) begin
`ifdef IFETCH_MISALIGN_CHECK_EN
        redirect($urandom & 32'hFFFF_FFFC, 1'b0);
`else
        redirect($urandom, 1'b0);
`endif
      end
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
